password_round_checker: RTL and testbench
=========================================

Name: password_round_checker

Overview:
- Round-execution end of the game-state interface: consumes the password, update strobe and start-time digits the game FSM drives; produces the one-cycle success/fail pulses it consumes.
- Holds the active password, runs a BCD seconds countdown from the level's start time, and compares the player's 10-bit switch guess on each submit press.
- Sits between switch/button debouncers and the game FSM; time digits also drive the 7-seg display mux.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per countdown second (≥2).
- PW_W, 10, password/guess width.
- MAX_TRIES, 3, wrong-guess limit (used only with ATTEMPT_LIMIT_EN); ≤3.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- update  in  1  load strobe from game FSM.
- new_password  in  PW_W  password, valid while update=1.
- start_time_left  in  4  start tens digit, BCD.
- start_time_right  in  4  start ones digit, BCD.
- guess  in  PW_W  player switches.
- submit  in  1  debounced submit button (level).
- success  out  1  one-cycle pulse, correct guess.
- fail  out  1  one-cycle pulse, timeout (or attempt limit).
- time_left  out  4  remaining tens, BCD.
- time_right  out  4  remaining ones, BCD.
- armed  out  1  high while in RUN.
- wrong_count  out  2  wrong guesses this round, saturating at 3.

Behaviour:
- Clock and reset: clk clocks all state. Reset is synchronous, active-high; it has priority over everything.
- Reset values: state=IDLE, password reg=0, prescaler=0, submit_q=0, all outputs 0.
- All outputs are registered.
- States: IDLE, LOAD, RUN, DONE.
- update=1 in any state (reset low): latch new_password, go LOAD next cycle. This overrides every RUN action in that cycle.
- LOAD, one cycle: sample start_time_left/right into time_left/right; a digit >9 clamps to 9. Clear prescaler and wrong_count, go RUN.
- Start digits are sampled one cycle after update because the FSM drives them from its next state.
- RUN, prescaler: counts 0..TICK_DIV-1 and wraps. On the wrap cycle, decrement the BCD time:
  - right>0 → right-1;
  - else left>0 → left-1, right=9;
  - 00 stays 00.
- RUN, timeout: if time is 00 at a clock edge (no edge event, no update), pulse fail next cycle and go DONE. Start time 00 therefore fails 1 cycle after entering RUN.
- RUN, submit: a rising edge (submit=1, submit_q=0) is evaluated the same cycle.
  - guess==password → success=1 next cycle, go DONE.
  - Otherwise wrong_count increments, saturating at 3.
- Simultaneous events: a correct submit edge in the same cycle as time reaching 00 → success wins, no fail.
- Submit held across LOAD→RUN: does not count as an edge (submit_q tracks continuously).
- DONE: time frozen, armed=0. Waits for update (next level) or reset.
- Pulse rules: success and fail are each high exactly one cycle; never both.
- Interlock with the FSM: the FSM raises update combinationally in the cycle it sees success. That update is accepted in DONE's first cycle and goes to LOAD.
- IDLE: armed=0, time 00, submit ignored.
- Width rule: compare is a full PW_W equality; no partial match.

Optional Feature:
- Macro ATTEMPT_LIMIT_EN.
- Defined: when a wrong submit makes wrong_count reach MAX_TRIES, pulse fail next cycle and go DONE. A correct guess on any earlier try still wins.
- Undefined: wrong guesses only increment the saturating wrong_count; fail comes from timeout alone.

Test Plan (TICK_DIV=4):
- reset, then update with pw=0x333, start 0/3 → LOAD, then RUN with time 0/3. Time reads 0/2, 0/1, 0/0 at 4-cycle spacing. fail pulses once one cycle after 0/0; state DONE; success never high.
- Load pw=0x2CD, start 9/0; guess=0x2CD, submit edge → success high exactly 1 cycle, time frozen. update with pw=0x394 in DONE's first cycle → LOAD, RUN with new start 6/0.
- Start 1/0, wait one tick → time 0/9 (borrow). Wrong guess 0x000 submitted twice → wrong_count=2, no fail (macro undefined). Submit held high 20 cycles → counts once.
- Correct submit edge on the cycle time reaches 00 → success=1, fail=0.
- reset asserted mid-RUN at time 0/5 → next cycle IDLE, all outputs 0. Later submit with the old password → no success.
- ATTEMPT_LIMIT_EN, MAX_TRIES=3: three wrong submits at start 9/0 → fail 1 cycle after the third; wrong_count=3. A correct guess on the third try → success instead.

Source files
------------

// File: rtl/password_round_checker.sv
// password_round_checker: holds the round password, runs a BCD seconds countdown
// and judges submit presses. Define ATTEMPT_LIMIT_EN to also fail on MAX_TRIES wrong guesses.
module password_round_checker #(
   parameter int TICK_DIV  = 100_000_000,
   parameter int PW_W      = 10,
   parameter int MAX_TRIES = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            update,
   input  logic [PW_W-1:0] new_password,
   input  logic [3:0]      start_time_left,
   input  logic [3:0]      start_time_right,
   input  logic [PW_W-1:0] guess,
   input  logic            submit,
   output logic            success,
   output logic            fail,
   output logic [3:0]      time_left,
   output logic [3:0]      time_right,
   output logic            armed,
   output logic [1:0]      wrong_count
);

   localparam int PS_W = $clog2(TICK_DIV);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
   localparam logic [1:0] TRY_LAST = 2'(MAX_TRIES);
`ifdef ATTEMPT_LIMIT_EN
   localparam logic LIMIT_EN = 1'b1;
`else
   localparam logic LIMIT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t            state, state_n;
   logic [PW_W-1:0]   pw_q, pw_n;
   logic [PS_W-1:0]   ps_q, ps_n;
   logic              submit_q;
   logic              success_n, fail_n, armed_n;
   logic [3:0]        tl_n, tr_n;
   logic [1:0]        wc_n, wc_inc;
   logic              sub_rise, hit, at_zero, limit_hit;

   function automatic logic [3:0] clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   assign sub_rise  = submit & ~submit_q;
   assign hit       = (guess == pw_q);
   assign at_zero   = (time_left == 4'd0) && (time_right == 4'd0);
   assign wc_inc    = (wrong_count == 2'd3) ? 2'd3 : wrong_count + 2'd1;
   assign limit_hit = LIMIT_EN && sub_rise && (wc_inc == TRY_LAST);

   // Register state and all outputs; reset clears everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pw_q        <= '0;
         ps_q        <= '0;
         submit_q    <= 1'b0;
         success     <= 1'b0;
         fail        <= 1'b0;
         time_left   <= 4'd0;
         time_right  <= 4'd0;
         armed       <= 1'b0;
         wrong_count <= 2'd0;
      end else begin
         state       <= state_n;
         pw_q        <= pw_n;
         ps_q        <= ps_n;
         submit_q    <= submit;
         success     <= success_n;
         fail        <= fail_n;
         time_left   <= tl_n;
         time_right  <= tr_n;
         armed       <= armed_n;
         wrong_count <= wc_n;
      end
   end

   // Next state and next output values; update overrides every round action.
   always_comb begin
      state_n   = state;
      pw_n      = pw_q;
      ps_n      = ps_q;
      tl_n      = time_left;
      tr_n      = time_right;
      wc_n      = wrong_count;
      success_n = 1'b0;
      fail_n    = 1'b0;
      if (update) begin
         pw_n    = new_password;
         state_n = LOAD;
      end else begin
         unique case (state)
            IDLE: ;
            LOAD: begin
               tl_n    = clamp9(start_time_left);
               tr_n    = clamp9(start_time_right);
               ps_n    = '0;
               wc_n    = 2'd0;
               state_n = RUN;
            end
            RUN: begin
               if (sub_rise && hit) begin
                  success_n = 1'b1;
                  state_n   = DONE;
               end else if (at_zero) begin
                  fail_n  = 1'b1;
                  state_n = DONE;
               end else begin
                  if (sub_rise) wc_n = wc_inc;
                  if (limit_hit) begin
                     fail_n  = 1'b1;
                     state_n = DONE;
                  end else if (ps_q == PS_LAST) begin
                     ps_n = '0;
                     if (time_right != 4'd0) begin
                        tr_n = time_right - 4'd1;
                     end else begin
                        tl_n = time_left - 4'd1;
                        tr_n = 4'd9;
                     end
                  end else begin
                     ps_n = ps_q + PS_W'(1);
                  end
               end
            end
            DONE: ;
         endcase
      end
      armed_n = (state_n == RUN);
   end

endmodule

// File: tb/tb_password_round_checker.sv
// tb_password_round_checker: vector table, hand sequences and random
// stimulus against a seconds-based reference model.
module tb_password_round_checker;

   localparam int TD = 4;
   localparam int MT = 3;
`ifdef ATTEMPT_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0, update = 1'b0, submit = 1'b0;
   logic [9:0] new_password = '0, guess = '0;
   logic [3:0] sl = '0, sr = '0;
   logic       success, fail, armed;
   logic [3:0] time_left, time_right;
   logic [1:0] wrong_count;

   always #5 clk = ~clk;

   password_round_checker #(.TICK_DIV(TD), .PW_W(10), .MAX_TRIES(MT)) dut (
      .clk(clk), .reset(reset), .update(update),
      .new_password(new_password),
      .start_time_left(sl), .start_time_right(sr),
      .guess(guess), .submit(submit),
      .success(success), .fail(fail),
      .time_left(time_left), .time_right(time_right),
      .armed(armed), .wrong_count(wrong_count)
   );

   int checks = 0;
   int failures = 0;

   // reference model: phase 0 idle, 1 load, 2 run, 3 done; time as whole seconds
   int         m_phase = 0, m_secs = 0, m_cyc = 0, m_wr = 0;
   logic [9:0] m_pw = '0;
   bit         m_prev = 0, m_succ = 0, m_fail = 0, m_arm = 0;

   function automatic int dmin9(int d);
      return (d > 9) ? 9 : d;
   endfunction

   task automatic model_step();
      bit e;
      e = submit && !m_prev;
      m_succ = 0;
      m_fail = 0;
      if (reset) begin
         m_phase = 0; m_secs = 0; m_cyc = 0; m_wr = 0;
         m_pw = '0; m_prev = 0; m_arm = 0;
         return;
      end
      if (update) begin
         m_pw = new_password;
         m_phase = 1;
      end else if (m_phase == 1) begin
         m_secs = dmin9(int'(sl)) * 10 + dmin9(int'(sr));
         m_cyc = 0;
         m_wr = 0;
         m_phase = 2;
      end else if (m_phase == 2) begin
         if (e && guess == m_pw) begin
            m_succ = 1; m_phase = 3;
         end else if (m_secs == 0) begin
            m_fail = 1; m_phase = 3;
         end else begin
            if (e && m_wr < 3) m_wr++;
            if (LIM && e && m_wr == MT) begin
               m_fail = 1; m_phase = 3;
            end else begin
               m_cyc++;
               if (m_cyc == TD) begin
                  m_cyc = 0;
                  m_secs--;
               end
            end
         end
      end
      m_arm = (m_phase == 2);
      m_prev = submit;
   endtask

   task automatic check_model(string tag);
      logic [11:0] got, want;
      got  = {success, fail, time_left, time_right, armed, wrong_count};
      want = {m_succ, m_fail, 4'(m_secs / 10), 4'(m_secs % 10), m_arm, 2'(m_wr)};
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL model_%s got s=%0b f=%0b t=%0d/%0d a=%0b wc=%0d want s=%0b f=%0b t=%0d/%0d a=%0b wc=%0d",
                  tag, success, fail, time_left, time_right, armed, wrong_count,
                  m_succ, m_fail, m_secs / 10, m_secs % 10, m_arm, m_wr);
      end
   endtask

   task automatic check_exp(string tag, bit es, bit ef, logic [3:0] etl,
                            logic [3:0] etr, bit ea, logic [1:0] ewc);
      checks++;
      if ({success, fail, time_left, time_right, armed, wrong_count}
          !== {es, ef, etl, etr, ea, ewc}) begin
         failures++;
         $display("FAIL %s got s=%0b f=%0b t=%0d/%0d a=%0b wc=%0d want s=%0b f=%0b t=%0d/%0d a=%0b wc=%0d",
                  tag, success, fail, time_left, time_right, armed, wrong_count,
                  es, ef, etl, etr, ea, ewc);
      end
   endtask

   task automatic step(string tag, bit r, bit u, logic [9:0] np, logic [3:0] l,
                       logic [3:0] rr, logic [9:0] g, bit s);
      reset = r; update = u; new_password = np;
      sl = l; sr = rr; guess = g; submit = s;
      @(posedge clk);
      model_step();
      #1;
      check_model(tag);
   endtask

   typedef struct {
      bit r; bit u; logic [9:0] pw; logic [3:0] l; logic [3:0] rr;
      logic [9:0] g; bit s; int rep;
      bit es; bit ef; logic [3:0] etl; logic [3:0] etr; bit ea; logic [1:0] ewc;
   } vec_t;

   function automatic vec_t v(bit r, bit u, logic [9:0] pw, logic [3:0] l,
                              logic [3:0] rr, logic [9:0] g, bit s, int rep,
                              bit es, bit ef, logic [3:0] etl, logic [3:0] etr,
                              bit ea, logic [1:0] ewc);
      vec_t x;
      x.r = r; x.u = u; x.pw = pw; x.l = l; x.rr = rr; x.g = g; x.s = s;
      x.rep = rep; x.es = es; x.ef = ef; x.etl = etl; x.etr = etr;
      x.ea = ea; x.ewc = ewc;
      return x;
   endfunction

   vec_t tbl[$];

   initial begin
      logic [9:0] g;
      bit s;
      // timeout round, start 0/3
      tbl.push_back(v(1,0,10'h000,0,0,10'h000,0,1,  0,0,0,0,0,0));
      tbl.push_back(v(0,1,10'h333,0,3,10'h000,0,1,  0,0,0,0,0,0));
      tbl.push_back(v(0,0,10'h000,0,3,10'h000,0,1,  0,0,0,3,1,0));
      tbl.push_back(v(0,0,10'h000,0,3,10'h000,0,4,  0,0,0,2,1,0));
      tbl.push_back(v(0,0,10'h000,0,3,10'h000,0,4,  0,0,0,1,1,0));
      tbl.push_back(v(0,0,10'h000,0,3,10'h000,0,4,  0,0,0,0,1,0));
      tbl.push_back(v(0,0,10'h000,0,3,10'h000,0,1,  0,1,0,0,0,0));
      tbl.push_back(v(0,0,10'h000,0,3,10'h000,0,1,  0,0,0,0,0,0));
      // correct guess, then update in first DONE cycle
      tbl.push_back(v(0,1,10'h2CD,9,0,10'h000,0,1,  0,0,0,0,0,0));
      tbl.push_back(v(0,0,10'h000,9,0,10'h000,0,1,  0,0,9,0,1,0));
      tbl.push_back(v(0,0,10'h000,9,0,10'h2CD,1,1,  1,0,9,0,0,0));
      tbl.push_back(v(0,1,10'h394,6,0,10'h2CD,0,1,  0,0,9,0,0,0));
      tbl.push_back(v(0,0,10'h000,6,0,10'h000,0,1,  0,0,6,0,1,0));
      // update mid-RUN, borrow, held submit, wrong guesses
      tbl.push_back(v(0,1,10'h1AB,1,0,10'h000,0,1,  0,0,6,0,0,0));
      tbl.push_back(v(0,0,10'h000,1,0,10'h000,0,1,  0,0,1,0,1,0));
      tbl.push_back(v(0,0,10'h000,1,0,10'h000,0,4,  0,0,0,9,1,0));
      tbl.push_back(v(0,0,10'h000,1,0,10'h000,1,20, 0,0,0,4,1,1));
      tbl.push_back(v(0,0,10'h000,1,0,10'h000,0,1,  0,0,0,4,1,1));
      tbl.push_back(v(0,0,10'h000,1,0,10'h000,1,1,  0,0,0,4,1,2));
      tbl.push_back(v(0,0,10'h000,1,0,10'h000,0,1,  0,0,0,4,1,2));
      // correct edge while time is 00
      tbl.push_back(v(0,1,10'h155,0,0,10'h000,0,1,  0,0,0,4,0,2));
      tbl.push_back(v(0,0,10'h000,0,0,10'h155,0,1,  0,0,0,0,1,0));
      tbl.push_back(v(0,0,10'h000,0,0,10'h155,1,1,  1,0,0,0,0,0));
      tbl.push_back(v(0,0,10'h000,0,0,10'h155,0,1,  0,0,0,0,0,0));
      // reset mid-RUN at 0/5, old password ignored afterwards
      tbl.push_back(v(0,1,10'h0F0,0,5,10'h000,0,1,  0,0,0,0,0,0));
      tbl.push_back(v(0,0,10'h000,0,5,10'h000,0,1,  0,0,0,5,1,0));
      tbl.push_back(v(1,0,10'h000,0,5,10'h0F0,0,1,  0,0,0,0,0,0));
      tbl.push_back(v(0,0,10'h000,0,0,10'h0F0,1,1,  0,0,0,0,0,0));
      tbl.push_back(v(0,0,10'h000,0,0,10'h0F0,0,3,  0,0,0,0,0,0));
      // digit clamp and full-width compare
      tbl.push_back(v(0,1,10'h3FF,12,15,10'h000,0,1, 0,0,0,0,0,0));
      tbl.push_back(v(0,0,10'h000,12,15,10'h000,0,1, 0,0,9,9,1,0));
      tbl.push_back(v(0,0,10'h000,12,15,10'h1FF,1,1, 0,0,9,9,1,1));
      tbl.push_back(v(0,0,10'h000,12,15,10'h3FF,0,1, 0,0,9,9,1,1));
      tbl.push_back(v(0,0,10'h000,12,15,10'h3FF,1,1, 1,0,9,9,0,1));

      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].rep; k++)
            step($sformatf("vec%0d", i), tbl[i].r, tbl[i].u, tbl[i].pw,
                 tbl[i].l, tbl[i].rr, tbl[i].g, tbl[i].s);
         check_exp($sformatf("vec%0d", i), tbl[i].es, tbl[i].ef,
                   tbl[i].etl, tbl[i].etr, tbl[i].ea, tbl[i].ewc);
      end

      // three wrong submits at start 9/0
      step("lim", 0, 1, 10'h2AA, 9, 0, 10'h000, 0);
      step("lim", 0, 0, 10'h000, 9, 0, 10'h000, 0);
      check_exp("lim_load", 0, 0, 9, 0, 1, 0);
      step("lim", 0, 0, 10'h000, 9, 0, 10'h000, 1);
      step("lim", 0, 0, 10'h000, 9, 0, 10'h000, 0);
      step("lim", 0, 0, 10'h000, 9, 0, 10'h000, 1);
      step("lim", 0, 0, 10'h000, 9, 0, 10'h000, 0);
      check_exp("lim_two", 0, 0, 8, 9, 1, 2);
      step("lim", 0, 0, 10'h000, 9, 0, 10'h000, 1);
      check_exp("lim_third", 0, LIM, 8, 9, !LIM, 3);
      step("lim", 0, 0, 10'h000, 9, 0, 10'h000, 0);
      check_exp("lim_after", 0, 0, 8, 9, !LIM, 3);

      // two wrong, then correct on the third try
      step("lim3", 0, 1, 10'h2AA, 9, 0, 10'h000, 0);
      step("lim3", 0, 0, 10'h000, 9, 0, 10'h000, 0);
      step("lim3", 0, 0, 10'h000, 9, 0, 10'h000, 1);
      step("lim3", 0, 0, 10'h000, 9, 0, 10'h000, 0);
      step("lim3", 0, 0, 10'h000, 9, 0, 10'h000, 1);
      step("lim3", 0, 0, 10'h000, 9, 0, 10'h2AA, 0);
      step("lim3", 0, 0, 10'h000, 9, 0, 10'h2AA, 1);
      check_exp("lim_correct3", 1, 0, 8, 9, 0, 2);

      // random rounds against the model
      s = 0;
      for (int i = 0; i < 4000; i++) begin
         g = ($urandom_range(0, 2) == 0) ? m_pw : 10'($urandom);
         if ($urandom_range(0, 3) == 0) s = !s;
         step("rand", $urandom_range(0, 599) == 0, $urandom_range(0, 29) == 0,
              10'($urandom), 4'($urandom_range(0, 2)),
              4'($urandom_range(0, 15)), g, s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
